graph_mem_arbiter: RTL and testbench
====================================

Name: graph_mem_arbiter

Overview:
- Shares one read port of graph_memory among NUM_REQ requesters, e.g. the initial position lookup, the graph_fetch second port and the top-k result readout.
- Replaces the ad-hoc state-based muxing in the search top level with round-robin arbitration, per-requester burst hold and in-order response routing via a tag FIFO.
- Sits between the search controller / graph_fetch and graph_memory port B.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_OUTSTANDING, 4, maximum in-flight reads; this is also the tag FIFO depth (power of 2).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous reset, active-low.
- req_valid_in  input  NUM_REQ  per-requester read request.
- req_addr_in  input  NUM_REQ x ADDR_W  per-requester address.
- req_hold_in  input  NUM_REQ  burst hold: keep the grant on this requester after its accept.
- req_ready_out  output  NUM_REQ  one-hot grant (combinational); a request is accepted when valid && ready.
- resp_data_out  output  DATA_W  returned data, shared by all requesters.
- resp_valid_out  output  NUM_REQ  one-hot, marks the owner of resp_data_out.
- mem_addr_out  output  ADDR_W  address to graph_memory.
- mem_valid_out  output  1  read strobe to graph_memory.
- mem_data_in  input  DATA_W  graph_memory read data.
- mem_valid_in  input  1  graph_memory read-data valid.
- busy_out  output  1  high while any read is in flight.
- error_out  output  1  sticky: a response arrived with the tag FIFO empty.

Behaviour:
- Reset (rst_in==0 at posedge): all outputs 0, rr pointer = 0, tag FIFO empty, error cleared. Reset mid-operation drops in-flight tags; responses arriving after reset release raise error_out.
- Grant (combinational):
  - If count == MAX_OUTSTANDING, no grant.
  - Else if the lock is active and the locked requester is valid, grant it.
  - Else grant the first valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - At most one ready bit set per cycle.
- On accept by requester i:
  - Next cycle: mem_addr_out = req_addr_in[i], mem_valid_out = 1.
  - Push tag i into the FIFO.
  - rr pointer <= (i+1) mod NUM_REQ.
  - lock <= req_hold_in[i], locked id <= i.
- Cycles with no accept: mem_valid_out = 0; mem_addr_out holds its last value.
- Lock release: when the locked requester deasserts hold, or deasserts valid for a cycle. The rr pointer resumes from i+1.
- On mem_valid_in:
  - Pop the FIFO head t.
  - Next cycle: resp_data_out = mem_data_in, resp_valid_out = one-hot(t).
  - Otherwise resp_valid_out = 0 and resp_data_out holds.
- Push and pop in the same cycle: count unchanged. Ready is gated on count < MAX_OUTSTANDING before the pop (conservative).
- mem_valid_in with the FIFO empty: set error_out, drop the data, no resp_valid_out.
- Responses are strictly in request order; memory latency may be any fixed or variable value ≥1, provided memory returns data in order.
- Request-to-response latency = 1 + memory latency + 1 cycles.
- busy_out = (count != 0) || mem_valid_out.
- Requesters must hold addr and valid stable until ready; the arbiter does not buffer requests.

Decomposition:
- Package graph_mem_pkg: ADDR_W/DATA_W defaults, tag type logic [$clog2(NUM_REQ)-1:0], request struct {addr, hold}.
- One sub-module: tag_fifo (synchronous FIFO of requester ids, depth MAX_OUTSTANDING, count/full/empty outputs, same active-low synchronous reset).
- Round-robin find-first stays as a function in the top.

Test Plan:
- Single requester 1 reads addr 0x10, memory latency 2 returns 0xAB → mem_valid_out at T+1 with addr 0x10; resp_valid_out = 3'b010 and data 0xAB at T+4.
- All three requesters valid continuously, no hold → grants 0,1,2,0,1,2…; responses return tagged in the same order, with data equal to addr+0x100 from a memory model.
- Requester 0 holds for a 3-beat burst (addrs 5,6,7) while requester 2 is valid → three consecutive grants to 0, then 2; no interleaving.
- Memory stalled (never asserts mem_valid_in) with 4 accepted requests → req_ready_out = 0 for all, busy_out = 1. After one response, exactly one new grant.
- mem_valid_in pulsed with no outstanding request → error_out = 1 and stays 1; no resp_valid_out. Clears only on rst_in = 0.
- Assert rst_in = 0 with 2 reads in flight → all outputs 0 next cycle, FIFO empty. A late memory response sets error_out; a new request afterwards completes normally.

Source files
------------

// File: rtl/graph_mem_pkg.sv
// Shared types for the graph memory read-port arbiter.
// Holds default widths, the requester tag type and the request bundle.
package graph_mem_pkg;

   localparam int GM_ADDR_W  = 32;
   localparam int GM_DATA_W  = 32;
   localparam int GM_MAX_REQ = 8;
   localparam int TAG_W      = $clog2(GM_MAX_REQ);

   // Wide enough for any supported requester count (2..8).
   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      logic [GM_ADDR_W-1:0] addr;
      logic                 hold;
   } req_t;

endpackage

// File: rtl/graph_mem_arbiter_tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per in-flight read.
// Ports: clk_in, rst_in (sync, active-low), push_in/push_tag_in,
//        pop_in, head_out, count_out, full_out, empty_out.
module tag_fifo
   import graph_mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push_in,
   input  tag_t                     push_tag_in,
   input  logic                     pop_in,
   output tag_t                     head_out,
   output logic [$clog2(DEPTH):0]   count_out,
   output logic                     full_out,
   output logic                     empty_out
);

   localparam int AW = $clog2(DEPTH);

   tag_t            r_mem [DEPTH];
   logic [AW-1:0]   r_wp;
   logic [AW-1:0]   r_rp;
   logic [AW:0]     r_cnt;
   logic            w_push;
   logic            w_pop;

   assign full_out  = (r_cnt == (AW+1)'(DEPTH));
   assign empty_out = (r_cnt == '0);
   assign count_out = r_cnt;
   assign head_out  = r_mem[r_rp];
   assign w_push    = push_in && !full_out;
   assign w_pop     = pop_in && !empty_out;

   always_ff @(posedge clk_in) begin
      if (w_push) r_mem[r_wp] <= push_tag_in;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter sharing one graph_memory read port among requesters,
// with burst hold and in-order response routing through a tag FIFO.
// Ports: clk_in, rst_in (sync, active-low); req_valid_in/req_addr_in/
//   req_hold_in/req_ready_out per requester; resp_data_out/resp_valid_out
//   back to requesters; mem_addr_out/mem_valid_out/mem_data_in/mem_valid_in
//   to memory; busy_out, error_out (sticky tag underflow).
module graph_mem_arbiter
   import graph_mem_pkg::*;
#(
   parameter int NUM_REQ         = 3,
   parameter int ADDR_W          = GM_ADDR_W,
   parameter int DATA_W          = GM_DATA_W,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [NUM_REQ-1:0]             req_valid_in,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in,
   input  logic [NUM_REQ-1:0]             req_hold_in,
   output logic [NUM_REQ-1:0]             req_ready_out,
   output logic [DATA_W-1:0]              resp_data_out,
   output logic [NUM_REQ-1:0]             resp_valid_out,
   output logic [ADDR_W-1:0]              mem_addr_out,
   output logic                           mem_valid_out,
   input  logic [DATA_W-1:0]              mem_data_in,
   input  logic                           mem_valid_in,
   output logic                           busy_out,
   output logic                           error_out
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   logic [IW-1:0]       r_rr;
   logic                r_lock;
   logic [IW-1:0]       r_lock_id;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_valid;
   logic [DATA_W-1:0]   r_resp_data;
   logic [NUM_REQ-1:0]  r_resp_valid;
   logic                r_err;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IW-1:0]       w_gid;
   logic                w_acc;
   logic                w_pop;
   tag_t                w_head;
   logic [CW-1:0]       w_count;
   logic                w_full;
   logic                w_empty;

   function automatic logic [NUM_REQ-1:0] rr_pick(
      input logic [NUM_REQ-1:0] v,
      input logic [IW-1:0]      ptr
   );
      logic [NUM_REQ-1:0] g;
      logic               found;
      int                 idx;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && v[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   // Ready is gated on the pre-pop count, so a full FIFO blocks a grant
   // even in the cycle a response frees a slot.
   always_comb begin
      w_grant = '0;
      if (rst_in && !w_full) begin
         if (r_lock && req_valid_in[r_lock_id])
            w_grant[r_lock_id] = 1'b1;
         else
            w_grant = rr_pick(req_valid_in, r_rr);
      end
   end

   always_comb begin
      w_gid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_grant[i]) w_gid = IW'(i);
   end

   assign w_acc = |w_grant;
   assign w_pop = mem_valid_in && !w_empty;

   tag_fifo #(
      .DEPTH       (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .push_in     (w_acc),
      .push_tag_in (TAG_W'(w_gid)),
      .pop_in      (w_pop),
      .head_out    (w_head),
      .count_out   (w_count),
      .full_out    (w_full),
      .empty_out   (w_empty)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_rr         <= '0;
         r_lock       <= 1'b0;
         r_lock_id    <= '0;
         r_mem_addr   <= '0;
         r_mem_valid  <= 1'b0;
         r_resp_data  <= '0;
         r_resp_valid <= '0;
         r_err        <= 1'b0;
      end else begin
         r_mem_valid <= w_acc;
         if (w_acc) begin
            r_mem_addr <= req_addr_in[w_gid];
            r_rr       <= (w_gid == IW'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
            r_lock     <= req_hold_in[w_gid];
            r_lock_id  <= w_gid;
         end else if (r_lock && (!req_valid_in[r_lock_id] ||
                                 !req_hold_in[r_lock_id])) begin
            r_lock <= 1'b0;
         end
         r_resp_valid <= '0;
         if (w_pop) begin
            r_resp_data  <= mem_data_in;
            r_resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_head[IW-1:0];
         end
         // Data with no owner is dropped; the flag stays until reset.
         if (mem_valid_in && w_empty) r_err <= 1'b1;
      end
   end

   assign req_ready_out  = w_grant;
   assign mem_addr_out   = r_mem_addr;
   assign mem_valid_out  = r_mem_valid;
   assign resp_data_out  = r_resp_data;
   assign resp_valid_out = r_resp_valid;
   assign busy_out       = (w_count != '0) || r_mem_valid;
   assign error_out      = r_err;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter with a behavioural memory model
// (latency 2, optional stall, single-beat release and stray-pulse inject).
module tb_graph_mem_arbiter;

   logic             clk;
   logic             rst_in;
   logic [2:0]       req_valid_in;
   logic [2:0][31:0] req_addr_in;
   logic [2:0]       req_hold_in;
   logic [2:0]       req_ready_out;
   logic [31:0]      resp_data_out;
   logic [2:0]       resp_valid_out;
   logic [31:0]      mem_addr_out;
   logic             mem_valid_out;
   logic [31:0]      mem_data_in;
   logic             mem_valid_in;
   logic             busy_out;
   logic             error_out;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic stall = 1'b0;
   int   inj_req = 0, inj_done = 0;
   int   rel_req = 0, rel_done = 0;
   int   fl_req  = 0, fl_done  = 0;

   typedef struct { logic [31:0] d; int due; } mreq_t;
   mreq_t mq[$];

   typedef struct { logic [2:0] oh; logic [31:0] d; } exp_t;

   graph_mem_arbiter dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .req_valid_in   (req_valid_in),
      .req_addr_in    (req_addr_in),
      .req_hold_in    (req_hold_in),
      .req_ready_out  (req_ready_out),
      .resp_data_out  (resp_data_out),
      .resp_valid_out (resp_valid_out),
      .mem_addr_out   (mem_addr_out),
      .mem_valid_out  (mem_valid_out),
      .mem_data_in    (mem_data_in),
      .mem_valid_in   (mem_valid_in),
      .busy_out       (busy_out),
      .error_out      (error_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h10) ? 32'hAB : a + 32'h100;
   endfunction

   initial begin
      mem_valid_in = 1'b0;
      mem_data_in  = '0;
   end

   // Memory: requests seen while mem_valid_out is high return two cycles later.
   always @(negedge clk) begin
      if (fl_req != fl_done) begin
         mq.delete();
         fl_done = fl_req;
      end
      if (mem_valid_out) mq.push_back('{mem_model(mem_addr_out), cyc + 2});
      mem_valid_in = 1'b0;
      if (inj_req != inj_done) begin
         mem_valid_in = 1'b1;
         mem_data_in  = 32'hDEAD;
         inj_done     = inj_req;
      end else if (mq.size() > 0 && mq[0].due <= cyc &&
                   (!stall || rel_req != rel_done)) begin
         mem_valid_in = 1'b1;
         mem_data_in  = mq[0].d;
         void'(mq.pop_front());
         if (rel_req != rel_done) rel_done = rel_done + 1;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_in       = 1'b0;
      req_valid_in = '0;
      req_hold_in  = '0;
      stall        = 1'b0;
      fl_req       = fl_req + 1;
      @(negedge clk);
      @(negedge clk);
      rst_in = 1'b1;
   endtask

   task automatic test_reset();
      rst_in       = 1'b0;
      req_valid_in = '0;
      req_hold_in  = '0;
      req_addr_in  = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({req_ready_out, resp_valid_out, mem_valid_out, busy_out, error_out}
          !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_ctl got %b want 0", {req_ready_out,
                  resp_valid_out, mem_valid_out, busy_out, error_out});
      end
      n_cmp++;
      if ({resp_data_out, mem_addr_out} !== 64'b0) begin
         n_bad++;
         $display("FAIL reset_data got %h/%h want 0", resp_data_out,
                  mem_addr_out);
      end
      rst_in = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      req_valid_in   = 3'b010;
      req_addr_in[1] = 32'h10;
      #1;
      n_cmp++;
      if (req_ready_out !== 3'b010) begin
         n_bad++;
         $display("FAIL single_ready got %b want 010", req_ready_out);
      end
      @(negedge clk);
      req_valid_in = '0;
      #1;
      n_cmp++;
      if (mem_valid_out !== 1'b1 || mem_addr_out !== 32'h10 || !busy_out) begin
         n_bad++;
         $display("FAIL single_mem got v=%b a=%h b=%b want 1/10/1",
                  mem_valid_out, mem_addr_out, busy_out);
      end
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (k < 4 && resp_valid_out !== 3'b000) begin
            n_bad++;
            $display("FAIL single_early cyc+%0d got %b want 000", k,
                     resp_valid_out);
         end
         if (k == 4 && (resp_valid_out !== 3'b010 ||
                        resp_data_out !== 32'hAB || busy_out !== 1'b0)) begin
            n_bad++;
            $display("FAIL single_resp got %b/%h/%b want 010/ab/0",
                     resp_valid_out, resp_data_out, busy_out);
         end
      end
   endtask

   task automatic test_round_robin();
      exp_t        eq[$];
      logic [31:0] a[3];
      logic [2:0]  g;
      int          got = 0;
      do_reset();
      a[0] = 32'h40; a[1] = 32'h50; a[2] = 32'h60;
      for (int t = 0; t < 16; t++) begin
         @(negedge clk);
         if (resp_valid_out !== 3'b000) begin
            n_cmp++;
            got++;
            if (eq.size() == 0) begin
               n_bad++;
               $display("FAIL rr_resp got %b/%h want none", resp_valid_out,
                        resp_data_out);
            end else begin
               if (resp_valid_out !== eq[0].oh || resp_data_out !== eq[0].d) begin
                  n_bad++;
                  $display("FAIL rr_resp got %b/%h want %b/%h", resp_valid_out,
                           resp_data_out, eq[0].oh, eq[0].d);
               end
               void'(eq.pop_front());
            end
         end
         if (t < 6) begin
            req_valid_in = 3'b111;
            for (int i = 0; i < 3; i++) req_addr_in[i] = a[i];
            #1;
            g = 3'b001 << (t % 3);
            n_cmp++;
            if (req_ready_out !== g) begin
               n_bad++;
               $display("FAIL rr_grant beat %0d got %b want %b", t,
                        req_ready_out, g);
            end
            eq.push_back('{g, a[t % 3] + 32'h100});
            a[t % 3] = a[t % 3] + 1;
         end else begin
            req_valid_in = '0;
         end
      end
      n_cmp++;
      if (got != 6) begin
         n_bad++;
         $display("FAIL rr_count got %0d want 6", got);
      end
   endtask

   task automatic test_burst_hold();
      do_reset();
      @(negedge clk);
      req_valid_in   = 3'b101;
      req_addr_in[0] = 32'd5;
      req_hold_in    = 3'b001;
      req_addr_in[2] = 32'h77;
      #1;
      n_cmp++;
      if (req_ready_out !== 3'b001) begin
         n_bad++;
         $display("FAIL burst_b0 got %b want 001", req_ready_out);
      end
      for (int b = 1; b <= 2; b++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_addr_out !== 32'(4 + b) || !mem_valid_out) begin
            n_bad++;
            $display("FAIL burst_addr%0d got %h want %h", b, mem_addr_out,
                     32'(4 + b));
         end
         req_addr_in[0] = 32'(5 + b);
         req_hold_in    = (b == 2) ? 3'b000 : 3'b001;
         #1;
         n_cmp++;
         if (req_ready_out !== 3'b001) begin
            n_bad++;
            $display("FAIL burst_b%0d got %b want 001", b, req_ready_out);
         end
      end
      @(negedge clk);
      req_addr_in[0] = 32'd8;
      #1;
      n_cmp++;
      if (req_ready_out !== 3'b100 || mem_addr_out !== 32'd7) begin
         n_bad++;
         $display("FAIL burst_release got %b/%h want 100/7", req_ready_out,
                  mem_addr_out);
      end
      @(negedge clk);
      req_valid_in = '0;
      n_cmp++;
      if (mem_addr_out !== 32'h77) begin
         n_bad++;
         $display("FAIL burst_next got %h want 77", mem_addr_out);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_stall();
      do_reset();
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid_in   = 3'b010;
         req_addr_in[1] = 32'hA0 + 32'(k);
         #1;
         n_cmp++;
         if (req_ready_out !== 3'b010) begin
            n_bad++;
            $display("FAIL stall_fill%0d got %b want 010", k, req_ready_out);
         end
      end
      @(negedge clk);
      req_addr_in[1] = 32'hA4;
      #1;
      n_cmp++;
      if (req_ready_out !== 3'b000 || busy_out !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_full got %b/%b want 000/1", req_ready_out,
                  busy_out);
      end
      rel_req = rel_req + 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (req_ready_out !== ((k == 1) ? 3'b010 : 3'b000)) begin
            n_bad++;
            $display("FAIL stall_one%0d got %b want %b", k, req_ready_out,
                     (k == 1) ? 3'b010 : 3'b000);
         end
      end
      req_valid_in = '0;
      stall        = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (busy_out !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_drain busy got %b want 0", busy_out);
      end
   endtask

   task automatic test_error();
      do_reset();
      @(negedge clk);
      #1;
      inj_req = inj_req + 1;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (error_out !== 1'b1 || resp_valid_out !== 3'b000) begin
         n_bad++;
         $display("FAIL err_set got %b/%b want 1/000", error_out,
                  resp_valid_out);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (error_out !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sticky got %b want 1", error_out);
      end
      rst_in = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (error_out !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear got %b want 0", error_out);
      end
      rst_in = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      stall = 1'b1;
      @(negedge clk);
      req_valid_in   = 3'b011;
      req_addr_in[0] = 32'h30;
      req_addr_in[1] = 32'h31;
      #1;
      n_cmp++;
      if (req_ready_out !== 3'b001) begin
         n_bad++;
         $display("FAIL mid_g0 got %b want 001", req_ready_out);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (req_ready_out !== 3'b010) begin
         n_bad++;
         $display("FAIL mid_g1 got %b want 010", req_ready_out);
      end
      @(negedge clk);
      req_valid_in = '0;
      rst_in       = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({req_ready_out, resp_valid_out, mem_valid_out, busy_out,
           error_out} !== 9'b0 || mem_addr_out !== 32'h0) begin
         n_bad++;
         $display("FAIL mid_reset got %b/%h want 0", {req_ready_out,
                  resp_valid_out, mem_valid_out, busy_out, error_out},
                  mem_addr_out);
      end
      rst_in = 1'b1;
      stall  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (resp_valid_out !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_late_resp got %b want 000", resp_valid_out);
         end
      end
      n_cmp++;
      if (error_out !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_late_err got %b want 1", error_out);
      end
      @(negedge clk);
      req_valid_in   = 3'b100;
      req_addr_in[2] = 32'h90;
      #1;
      n_cmp++;
      if (req_ready_out !== 3'b100) begin
         n_bad++;
         $display("FAIL mid_new_grant got %b want 100", req_ready_out);
      end
      @(negedge clk);
      req_valid_in = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (resp_valid_out !== 3'b100 || resp_data_out !== 32'h190) begin
         n_bad++;
         $display("FAIL mid_new_resp got %b/%h want 100/190", resp_valid_out,
                  resp_data_out);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_burst_hold();
      test_stall();
      test_error();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
